keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix scanner and debouncer for the board's 4x4 keypad. It drives the keypad columns, samples the rows, and debounces whole-matrix snapshots. It presents a stable 16-bit pressed-key vector that feeds the GPIO block's `keypad` input, which software reads at offset 0x004. It also emits a one-cycle press event with the code of the newly pressed key, for future interrupt use.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven; minimum 4.
- `DEBOUNCE_SCANS`, default 8: number of consecutive identical full-matrix frames required before `keypad` updates; minimum 2.
- `clk`  in  1  system clock, the same clock as the GPIO AXI side.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low (`rst` low = reset).
- `row_n`  in  4  keypad rows, externally pulled up, low when a key in the driven column is pressed. Asynchronous to `clk`.
- `col_n`  out  4  column drive, active-low, exactly one bit low at any time.
- `keypad`  out  16  debounced pressed-key vector. Bit index = row*4 + col.
- `key_press`  out  1  one-cycle pulse when `keypad` gains at least one newly set bit.
- `key_code`  out  4  lowest index among the newly set bits. Valid with `key_press`; holds its value otherwise.

## Operation
- **Row synchronizer.** `row_n` passes through a 2-flop synchronizer; everything below uses the synchronized rows.
- **Column scan.**
  - A dwell counter counts 0..SCAN_DIV-1.
  - A 2-bit column index `col` selects the driven column: `col_n` = ~(1 << col).
  - On the cycle the dwell counter equals SCAN_DIV-1:
    - inverted synchronized rows are written into `frame` bits {12+col, 8+col, 4+col, col};
    - the counter wraps to 0;
    - `col` increments modulo 4.
  - Sampling only on the last dwell cycle gives the synchronizer and the matrix SCAN_DIV-1 cycles to settle after a column change.
- **Frame completion.** The write of column 3 completes a frame (`frame_done`). `frame_done` uses the fully assembled 16-bit value, including the column-3 bits written that cycle.
- **Debounce.** Registers `cand[15:0]` and `cnt` (width clog2(DEBOUNCE_SCANS+1)). On `frame_done`:
  - If frame != `cand`: `cand` <= frame, `cnt` <= 1.
  - Else if `cnt` != DEBOUNCE_SCANS: `cnt` <= `cnt` + 1. If `cnt` + 1 == DEBOUNCE_SCANS, commit `keypad` <= frame.
  - Else (saturated): no change.
- **Press event.** On commit, new = frame & ~`keypad`(old).
  - If new != 0: `key_press` = 1 for that cycle and `key_code` = index of the lowest set bit of new.
  - A release-only commit updates `keypad` with no pulse; `key_code` holds.
- **Simultaneous keys.** Multiple keys are reported as-is. Ghosting is not filtered (no diodes assumed on the board matrix).

## Timing
- **Reset values** (all apply immediately on `rst` low, asynchronously):
  - `col_n` = 4'b1110 (column 0 driven);
  - `keypad` = 16'h0000, `key_press` = 0, `key_code` = 4'h0;
  - dwell counter = 0, `col` = 0, `frame` = 0, `cand` = 0;
  - `cnt` = DEBOUNCE_SCANS (saturated, so an idle matrix causes no commit).
- **After reset release:** column 0 is driven for SCAN_DIV cycles, then 1, 2, 3, and repeats. The frame period is 4*SCAN_DIV cycles.
- **Latency:** a key held stable from before a frame's column-0 sample commits at the end of the DEBOUNCE_SCANS-th frame containing it. `keypad` and `key_press` are registered and change on the same edge as the final column-3 sample.
- **Boundaries:**
  - A change arriving mid-frame may yield one partial frame. That frame resets `cnt` to 1, adding at most one extra frame of latency.
  - `key_press` is never high for two consecutive cycles.
  - Reset asserted mid-scan discards the partial frame and the debounce state. Scanning restarts at column 0 after release.
  - Press and release of different keys within the same committed frame: `keypad` reflects both; `key_press` fires for the pressed key.

## Test plan
Use SCAN_DIV=4 and DEBOUNCE_SCANS=3 (frame = 16 cycles). The bench models the matrix as row_n[r] = ~OR over c of (pressed[r*4+c] & ~col_n[c]).
- **Reset and scan:** hold `rst` low, then release. Required: `col_n` = 1110, `keypad` = 0, `key_press` = 0 during reset. After release, `col_n` steps 1110 -> 1101 -> 1011 -> 0111 every 4 cycles, and back to 1110 at cycle 16.
- **Single key:** press key 5 (row 1, col 1) at frame start and hold. Required: `keypad` = 16'h0020 at the end of the 3rd frame, `key_press` high exactly 1 cycle, `key_code` = 5. No further pulses while held.
- **Bounce rejection:** alternate key 5 pressed/released on every frame boundary for 10 frames, then release. Required: `keypad` stays 16'h0000 and `key_press` never asserts.
- **Multi-key and release:**
  - Press keys 0 and 15 together. Required: `keypad` = 16'h8001, one pulse with `key_code` = 0.
  - Release key 0. Required: `keypad` = 16'h8000 after 3 frames, no pulse, `key_code` stays 0.
  - Release all. Required: `keypad` = 16'h0000.
- **Async reset mid-operation:** with `keypad` = 16'h0020, drop `rst` between clock edges during column 2. Required: outputs take reset values before the next edge. After release with key 5 still held, `keypad` recommits 16'h0020 after 3 full frames, with one `key_press` carrying `key_code` = 5.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with whole-frame debounce.
// Presents a stable pressed-key vector and a one-cycle press event carrying the lowest new key index.
module keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] keypad,
    output logic        key_press,
    output logic [3:0]  key_code
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SAT    = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [3:0]    row_meta_q, row_sync_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_q, col_d;
    logic [15:0]   frame_q, frame_d;
    logic [15:0]   cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   keypad_q, keypad_d;
    logic          key_press_q, key_press_d;
    logic [3:0]    key_code_q, key_code_d;

    logic          last_dwell;
    logic          frame_done;
    logic [15:0]   new_keys;
    logic [3:0]    lowest_new;

    // Rows idle high (pulled up), so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row_n;
            row_sync_q <= row_meta_q;
        end
    end

    assign last_dwell = (dwell_q == DWELL_LAST);
    assign frame_done = last_dwell && (col_q == 2'd3);
    assign col_n      = ~(4'b0001 << col_q);

    always_comb begin
        dwell_d = dwell_q + 1'b1;
        col_d   = col_q;
        frame_d = frame_q;
        if (last_dwell) begin
            dwell_d = '0;
            col_d   = col_q + 2'd1;
            for (int r = 0; r < 4; r++) begin
                frame_d[{2'(r), col_q}] = ~row_sync_q[r];
            end
        end
    end

    // Newly pressed keys are judged against the committed vector, not the candidate.
    assign new_keys = frame_d & ~keypad_q;

    always_comb begin
        lowest_new = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (new_keys[i]) begin
                lowest_new = 4'(i);
            end
        end
    end

    always_comb begin
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        keypad_d    = keypad_q;
        key_press_d = 1'b0;
        key_code_d  = key_code_q;
        if (frame_done) begin
            if (frame_d != cand_q) begin
                cand_d = frame_d;
                cnt_d  = CNT_ONE;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_d == CNT_SAT) begin
                    keypad_d = frame_d;
                    if (new_keys != 16'h0000) begin
                        key_press_d = 1'b1;
                        key_code_d  = lowest_new;
                    end
                end
            end
        end
    end

    // Counter starts saturated so an idle matrix after reset never commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_q     <= '0;
            col_q       <= 2'd0;
            frame_q     <= 16'h0000;
            cand_q      <= 16'h0000;
            cnt_q       <= CNT_SAT;
            keypad_q    <= 16'h0000;
            key_press_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            dwell_q     <= dwell_d;
            col_q       <= col_d;
            frame_q     <= frame_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            keypad_q    <= keypad_d;
            key_press_q <= key_press_d;
            key_code_q  <= key_code_d;
        end
    end

    assign keypad    = keypad_q;
    assign key_press = key_press_q;
    assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized scoreboard bench for keypad_scan: a frame-level keypad model predicts commits,
// a monitor pops expectations whenever the DUT changes keypad or pulses key_press.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keypad;
    logic        key_press;
    logic [3:0]  key_code;
    logic [15:0] pressed = 16'h0000;

    int total = 0;
    int bad   = 0;

    // Frame-level reference: run length of identical frames, commit when it reaches DB.
    logic [15:0] m_run;
    logic [15:0] m_kp;
    int          m_len;
    logic [15:0] exp_kp_q[$];
    logic [3:0]  exp_code_q[$];

    logic [15:0] last_kp    = 16'h0000;
    logic        prev_press = 1'b0;
    logic [3:0]  hold_code  = 4'h0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .keypad    (keypad),
        .key_press (key_press),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] res;
        res = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) res = 4'(i);
        end
        return res;
    endfunction

    task automatic model_reset();
        m_run = 16'h0000;
        m_kp  = 16'h0000;
        m_len = DB;
        exp_kp_q.delete();
        exp_code_q.delete();
    endtask

    task automatic model_frame(input logic [15:0] f);
        logic [15:0] newk;
        if (f != m_run) begin
            m_run = f;
            m_len = 1;
        end else begin
            m_len++;
        end
        if (m_len == DB) begin
            newk = f & ~m_kp;
            if (f != m_kp) exp_kp_q.push_back(f);
            if (newk != 16'h0000) exp_code_q.push_back(lowest(newk));
            m_kp = f;
        end
    endtask

    task automatic finish_frame();
        @(negedge clk);
        #1;
        check("frame_keypad", {16'h0, keypad}, {16'h0, m_kp});
        check("sb_drained", exp_kp_q.size() + exp_code_q.size(), 0);
    endtask

    task automatic apply_frame(input logic [15:0] p);
        pressed = p;
        model_frame(p);
        repeat (SD * 4) @(posedge clk);
        finish_frame();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_col_n"}, {28'h0, col_n}, 32'hE);
        check({tag, "_keypad"}, {16'h0, keypad}, 32'h0);
        check({tag, "_key_press"}, {31'h0, key_press}, 32'h0);
        check({tag, "_key_code"}, {28'h0, key_code}, 32'h0);
    endtask

    // Monitor: consumes one expectation per observed DUT event.
    always @(negedge clk) begin
        if (!rst) begin
            last_kp    = 16'h0000;
            prev_press = 1'b0;
            hold_code  = 4'h0;
        end else begin
            if (key_press) begin
                check("press_not_back_to_back", {31'h0, prev_press}, 32'h0);
                if (exp_code_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_press: got code %0d want no pulse (t=%0t)", key_code, $time);
                end else begin
                    hold_code = exp_code_q.pop_front();
                    check("press_code", {28'h0, key_code}, {28'h0, hold_code});
                    $display("press event code=%0d keypad=%04h t=%0t", key_code, keypad, $time);
                end
            end
            if (keypad !== last_kp) begin
                if (exp_kp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_keypad: got %04h want %04h (t=%0t)", keypad, last_kp, $time);
                end else begin
                    check("keypad_update", {16'h0, keypad}, {16'h0, exp_kp_q.pop_front()});
                    $display("keypad commit %04h -> %04h t=%0t", last_kp, keypad, $time);
                end
                if (!key_press) check("key_code_hold", {28'h0, key_code}, {28'h0, hold_code});
                last_kp = keypad;
            end
            prev_press = key_press;
        end
    end

    initial begin
        int          kind;
        int          nfr;
        logic [15:0] one16;
        logic [15:0] p;

        one16 = 16'h0001;
        model_reset();

        // Reset and scan sequence
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        #1;
        rst = 1'b1;
        pressed = 16'h0000;
        model_frame(16'h0000);
        check("scan_k0", {28'h0, col_n}, 32'hE);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("scan_k%0d", k), {28'h0, col_n},
                  {28'h0, ~(4'b0001 << ((k / 4) % 4))});
        end
        finish_frame();

        // Single key 5 held, then released
        repeat (5) apply_frame(16'h0020);
        repeat (3) apply_frame(16'h0000);

        // Bounce rejection
        for (int i = 0; i < 10; i++) apply_frame((i % 2 == 0) ? 16'h0020 : 16'h0000);
        repeat (3) apply_frame(16'h0000);
        check("bounce_keypad", {16'h0, keypad}, 32'h0);

        // Multi-key, partial release, full release
        repeat (3) apply_frame(16'h8001);
        repeat (3) apply_frame(16'h8000);
        check("release_code_hold", {28'h0, key_code}, 32'h0);
        repeat (3) apply_frame(16'h0000);

        // Randomized segments
        for (int s = 0; s < 14; s++) begin
            kind = $urandom_range(0, 2);
            case (kind)
                0:       p = 16'h0000;
                1:       p = one16 << $urandom_range(0, 15);
                default: p = (one16 << $urandom_range(0, 15)) | (one16 << $urandom_range(0, 15));
            endcase
            nfr = $urandom_range(1, 4);
            repeat (nfr) apply_frame(p);
        end
        repeat (3) apply_frame(16'h0000);

        // Async reset mid-scan with key 5 committed and still held
        repeat (4) apply_frame(16'h0020);
        check("pre_reset_keypad", {16'h0, keypad}, 32'h20);
        repeat (9) @(posedge clk);
        check("pre_reset_col2", {28'h0, col_n}, 32'hB);
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (3) apply_frame(16'h0020);
        check("recommit_keypad", {16'h0, keypad}, 32'h20);
        repeat (3) apply_frame(16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
